hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_decoder_pkg.sv | 32 +++
 rtl/hamming_syndrome.sv | 17 +
 rtl/hamming_decoder.sv | 85 ++++++++
 tb/tb_hamming_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_decoder_pkg.sv
// Shared Hamming(7,4) geometry: widths, codeword bit positions and payload types.
package hamming_decoder_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  // Codeword bit positions (0-based); syndrome value is position + 1
  localparam int unsigned P1 = 0;
  localparam int unsigned P2 = 1;
  localparam int unsigned D0 = 2;
  localparam int unsigned P4 = 3;
  localparam int unsigned D1 = 4;
  localparam int unsigned D2 = 5;
  localparam int unsigned D3 = 6;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [SYN_W-1:0]  syndrome;
  } stage1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SYN_W-1:0]  syndrome;
    logic              corrected;
  } result_t;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[D3], code[D2], code[D1], code[D0]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(7,4) syndrome {s4,s2,s1}; zero means no single-bit error.
module hamming_syndrome
  import hamming_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syndrome
);

  logic s1, s2, s4;

  assign s1 = code[P1] ^ code[D0] ^ code[D1] ^ code[D3];
  assign s2 = code[P2] ^ code[D0] ^ code[D2] ^ code[D3];
  assign s4 = code[P4] ^ code[D1] ^ code[D2] ^ code[D3];

  assign syndrome = {s4, s2, s1};

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage pipelined Hamming(7,4) single-error-correcting decoder with valid/ready flow control.
// Optional corrected-word statistics counter enabled by `define HAMMING_DECODER_STATS_EN.
module hamming_decoder
  import hamming_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SYN_W-1:0]  out_syndrome,
  output logic              out_corrected
`ifdef HAMMING_DECODER_STATS_EN
  ,
  output logic [15:0]       err_count,
  input  logic              err_count_clr
`endif
);

  logic              adv;
  logic [SYN_W-1:0]  syn_in;
  logic              s1_valid;
  stage1_t           s1;
  result_t           res;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] fixed_code;

  // Whole pipeline advances whenever the output slot is empty or being drained
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  hamming_syndrome u_syndrome (
    .code     (in_code),
    .syndrome (syn_in)
  );

  // Flip the bit named by the syndrome; a double error lands on a wrong bit by design
  always_comb begin
    flip_mask = '0;
    if (s1.syndrome != '0) begin
      flip_mask = CODE_W'(1) << (s1.syndrome - SYN_W'(1));
    end
    fixed_code = s1.code ^ flip_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      res       <= '0;
    end else if (adv) begin
      s1_valid      <= in_valid;
      s1.code       <= in_code;
      s1.syndrome   <= syn_in;
      out_valid     <= s1_valid;
      res.data      <= extract_data(fixed_code);
      res.syndrome  <= s1.syndrome;
      res.corrected <= (s1.syndrome != '0);
    end
  end

  assign out_data      = res.data;
  assign out_syndrome  = res.syndrome;
  assign out_corrected = res.corrected;

`ifdef HAMMING_DECODER_STATS_EN
  localparam int unsigned CNT_W = 16;

  // Saturating count of corrected words delivered; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_count_clr) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_corrected && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed self-checking bench for hamming_decoder; stats checks compile only with HAMMING_DECODER_STATS_EN.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_corrected;
`ifdef HAMMING_DECODER_STATS_EN
  logic [15:0] err_count;
  logic        err_count_clr;
`endif

  int         checks   = 0;
  int         errors   = 0;
  int         received = 0;
  logic [7:0] expq[$];
  logic [7:0] mon_exp;
  logic [7:0] snap;

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_syndrome  (out_syndrome),
    .out_corrected (out_corrected)
`ifdef HAMMING_DECODER_STATS_EN
    ,
    .err_count     (err_count),
    .err_count_clr (err_count_clr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Clean codeword {d3,d2,d1,p4,d0,p2,p1}
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Expected {corrected, syndrome, data}; flip < 0 means an unflipped word
  function automatic logic [7:0] expect_word(input logic [3:0] d, input int flip);
    if (flip < 0) return {1'b0, 3'd0, d};
    return {1'b1, 3'(flip + 1), d};
  endfunction

  // Present a word at a negedge and hold it until accepted; returns on a negedge
  task automatic send(input logic [6:0] code);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_code  = code;
    do begin
      #1;
      acc = in_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 32'(acc), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic push_send(input logic [6:0] code, input logic [7:0] exp);
    expq.push_back(exp);
    send(code);
  endtask

  // Scoreboard: every delivered word must match the next expected one, in order
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      received++;
      if (expq.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'(0));
      end else begin
        mon_exp = expq.pop_front();
        check("out_word", 32'({out_corrected, out_syndrome, out_data}), 32'(mon_exp));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
`ifdef HAMMING_DECODER_STATS_EN
    err_count_clr = 1'b0;
`endif
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_syndrome", 32'(out_syndrome), 32'(0));
    check("rst_out_corrected", 32'(out_corrected), 32'(0));
`ifdef HAMMING_DECODER_STATS_EN
    check("rst_err_count", 32'(err_count), 32'(0));
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean word 0x55 -> data 1011, two cycles after accept
    push_send(7'h55, {1'b0, 3'd0, 4'b1011});
    check("lat_early_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'(1));
    check("clean_data", 32'(out_data), 32'(4'b1011));
    check("clean_syndrome", 32'(out_syndrome), 32'(0));
    check("clean_corrected", 32'(out_corrected), 32'(0));
    @(negedge clk);

    // 0x45 has bit 4 flipped -> syndrome 5, data restored
    push_send(7'h45, {1'b1, 3'd5, 4'b1011});
    @(negedge clk);
    check("flip_valid", 32'(out_valid), 32'(1));
    check("flip_data", 32'(out_data), 32'(4'b1011));
    check("flip_syndrome", 32'(out_syndrome), 32'(5));
    check("flip_corrected", 32'(out_corrected), 32'(1));
    @(negedge clk);

    // Every clean word and every single-bit flip, with periodic bubbles
    for (int d = 0; d < 16; d++) begin
      push_send(encode(4'(d)), expect_word(4'(d), -1));
      for (int p = 0; p < 7; p++) begin
        push_send(encode(4'(d)) ^ (7'd1 << p), expect_word(4'(d), p));
        if (p % 3 == 2) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    check("sweep_drained", 32'(expq.size()), 32'(0));
    check("sweep_received", 32'(received), 32'(130));

    // Back-pressure: stall the output for three cycles mid-stream
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          push_send(encode(4'(k + 5)) ^ (7'd1 << (k % 7)), expect_word(4'(k + 5), k % 7));
        end
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 20);
        out_ready = 1'b0;
        #1;
        snap = {out_corrected, out_syndrome, out_data};
        check("stall_in_ready", 32'(in_ready), 32'(0));
        repeat (2) begin
          @(negedge clk);
          #1;
          check("stall_in_ready", 32'(in_ready), 32'(0));
          check("stall_valid", 32'(out_valid), 32'(1));
          check("stall_hold", 32'({out_corrected, out_syndrome, out_data}), 32'(snap));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("stall_drained", 32'(expq.size()), 32'(0));
    check("stall_received", 32'(received), 32'(138));

    // Reset with two words in flight: nothing may emerge afterwards
    push_send(encode(4'd9) ^ 7'h01, expect_word(4'd9, 0));
    push_send(encode(4'd6) ^ 7'h40, expect_word(4'd6, 6));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_corrected", 32'(out_corrected), 32'(0));
    expq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      check("post_rst_idle", 32'(out_valid), 32'(0));
    end
    @(negedge clk);

`ifdef HAMMING_DECODER_STATS_EN
    // Three corrected plus one clean word
    err_count_clr = 1'b1;
    @(negedge clk);
    err_count_clr = 1'b0;
    check("stats_clr", 32'(err_count), 32'(0));
    push_send(encode(4'd1) ^ 7'h02, expect_word(4'd1, 1));
    push_send(encode(4'd2), expect_word(4'd2, -1));
    push_send(encode(4'd3) ^ 7'h08, expect_word(4'd3, 3));
    push_send(encode(4'd4) ^ 7'h20, expect_word(4'd4, 5));
    repeat (4) @(negedge clk);
    check("stats_count3", 32'(err_count), 32'(3));

    // Clear coinciding with a corrected handshake wins
    push_send(encode(4'd7) ^ 7'h04, expect_word(4'd7, 2));
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("stats_coinc_valid", 32'(out_valid && out_corrected), 32'(1));
    err_count_clr = 1'b1;
    @(negedge clk);
    err_count_clr = 1'b0;
    check("stats_clr_priority", 32'(err_count), 32'(0));

    // Saturation after 65536 corrected words
    for (int k = 0; k < 65536; k++) begin
      push_send(encode(4'(k)) ^ 7'h10, expect_word(4'(k), 4));
    end
    repeat (4) @(negedge clk);
    check("stats_saturate", 32'(err_count), 32'(16'hFFFF));
    check("stats_drained", 32'(expq.size()), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
